bh_cmd_parser: RTL and testbench



---
 rtl/bh_pkg.sv | 44 ++++
 rtl/bh_hex_ascii.sv | 42 ++++
 rtl/bh_cmd_parser.sv | 209 ++++++++++++++++++++
 tb/tb_bh_cmd_parser.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bh_pkg.sv
// Shared types, ASCII constants and character helpers for the BH command parser.
package bh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_HEX,
    ST_GET_IDX,
    ST_GET_BIT,
    ST_WAIT_TERM,
    ST_FLUSH,
    ST_EXEC,
    ST_REPLY
  } state_t;

  typedef enum logic [1:0] {
    CMD_LED,
    CMD_SET,
    CMD_QUERY
  } cmd_t;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_K  = 8'h4B;
  localparam logic [7:0] ASC_E  = 8'h45;
  localparam logic [7:0] ASC_L  = 8'h4C;
  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_Q  = 8'h3F;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_1  = 8'h31;
  localparam logic [7:0] ASC_3  = 8'h33;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) begin
      return c - 8'h20;
    end else begin
      return c;
    end
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASC_CR) || (c == ASC_LF);
  endfunction

endpackage

// File: rtl/bh_hex_ascii.sv
// Combinational ASCII hex digit decoder (case-insensitive, with valid flag)
// and nibble to uppercase ASCII hex encoder.
module bh_hex_ascii
  import bh_pkg::*;
(
  input  logic [7:0] asc,
  output logic [3:0] nib,
  output logic       nib_valid,
  input  logic [3:0] val,
  output logic [7:0] hex_asc
);

  logic [7:0] up;

  // Decode one ASCII character into a hex nibble.
  always_comb begin
    up        = to_upper(asc);
    nib       = 4'h0;
    nib_valid = 1'b0;
    if (up >= 8'h30 && up <= 8'h39) begin
      nib       = up[3:0];
      nib_valid = 1'b1;
    end else if (up >= 8'h41 && up <= 8'h46) begin
      // 'A'..'F' carry 1..6 in the low nibble
      nib       = up[3:0] + 4'd9;
      nib_valid = 1'b1;
    end else begin
      nib       = 4'h0;
      nib_valid = 1'b0;
    end
  end

  // Encode a nibble as uppercase ASCII hex.
  always_comb begin
    if (val < 4'd10) begin
      hex_asc = 8'h30 + {4'h0, val};
    end else begin
      hex_asc = 8'h37 + {4'h0, val};
    end
  end

endmodule

// File: rtl/bh_cmd_parser.sv
// Framed ASCII LED command parser with one-byte acknowledge.
// Optional frame timeout enabled by defining BH_CMD_TIMEOUT_EN.
module bh_cmd_parser
  import bh_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter logic [3:0]  LED_RST     = 4'h0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic [3:0] led,
  output logic       frame_err
);

  state_t     state_r, state_nx, cur_s;
  cmd_t       cmd_r, cmd_nx;
  logic [3:0] nib_r, nib_nx;
  logic [1:0] idx_r, idx_nx;
  logic       bit_r, bit_nx;
  logic [3:0] led_r, led_nx;
  logic       tx_en_r, tx_en_nx;
  logic [7:0] tx_data_r, tx_data_nx;
  logic       frame_err_r, frame_err_nx;

  logic [3:0] dec_nib_s;
  logic       dec_valid_s;
  logic [7:0] enc_asc_s;
  logic [7:0] rx_up_s;
  logic       rx_term_s;
  logic       timeout_hit_s;

  bh_hex_ascii u_hex (
    .asc       (rx_data),
    .nib       (dec_nib_s),
    .nib_valid (dec_valid_s),
    .val       (led_r),
    .hex_asc   (enc_asc_s)
  );

  assign rx_up_s   = to_upper(rx_data);
  assign rx_term_s = is_term(rx_data);

`ifdef BH_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;
  logic        parse_st_s;

  assign parse_st_s = (state_r == ST_GET_HEX) || (state_r == ST_GET_IDX) ||
                      (state_r == ST_GET_BIT) || (state_r == ST_WAIT_TERM) ||
                      (state_r == ST_FLUSH);
  assign timeout_hit_s = parse_st_s && (tmo_cnt_r == 32'(TIMEOUT_CYC - 32'd1));

  // Idle-cycle counter inside an open frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmo_cnt_r <= 32'd0;
    end else if (rx_done || !parse_st_s || timeout_hit_s) begin
      tmo_cnt_r <= 32'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and datapath decisions.
  always_comb begin
    cur_s        = timeout_hit_s ? ST_IDLE : state_r;
    state_nx     = cur_s;
    cmd_nx       = cmd_r;
    nib_nx       = nib_r;
    idx_nx       = idx_r;
    bit_nx       = bit_r;
    led_nx       = led_r;
    tx_en_nx     = 1'b0;
    tx_data_nx   = tx_data_r;
    frame_err_nx = timeout_hit_s;

    case (cur_s)
      ST_IDLE: begin
        if (rx_done) begin
          if (rx_up_s == ASC_L) begin
            cmd_nx   = CMD_LED;
            state_nx = ST_GET_HEX;
          end else if (rx_up_s == ASC_S) begin
            cmd_nx   = CMD_SET;
            state_nx = ST_GET_IDX;
          end else if (rx_data == ASC_Q) begin
            cmd_nx   = CMD_QUERY;
            state_nx = ST_WAIT_TERM;
          end else if (rx_term_s) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_FLUSH;
          end
        end else begin
          state_nx = cur_s;
        end
      end
      ST_GET_HEX, ST_GET_IDX, ST_GET_BIT: begin
        if (rx_done) begin
          if (rx_term_s) begin
            // frame cut short: reject immediately, nothing left to flush
            tx_data_nx   = ASC_E;
            frame_err_nx = 1'b1;
            state_nx     = ST_REPLY;
          end else if (cur_s == ST_GET_HEX && dec_valid_s) begin
            nib_nx   = dec_nib_s;
            state_nx = ST_WAIT_TERM;
          end else if (cur_s == ST_GET_IDX && rx_data >= ASC_0 && rx_data <= ASC_3) begin
            idx_nx   = rx_data[1:0];
            state_nx = ST_GET_BIT;
          end else if (cur_s == ST_GET_BIT && (rx_data == ASC_0 || rx_data == ASC_1)) begin
            bit_nx   = rx_data[0];
            state_nx = ST_WAIT_TERM;
          end else begin
            state_nx = ST_FLUSH;
          end
        end else begin
          state_nx = cur_s;
        end
      end
      ST_WAIT_TERM: begin
        if (rx_done) begin
          state_nx = rx_term_s ? ST_EXEC : ST_FLUSH;
        end else begin
          state_nx = cur_s;
        end
      end
      ST_FLUSH: begin
        if (rx_done && rx_term_s) begin
          tx_data_nx   = ASC_E;
          frame_err_nx = 1'b1;
          state_nx     = ST_REPLY;
        end else begin
          state_nx = cur_s;
        end
      end
      ST_EXEC: begin
        frame_err_nx = rx_done;
        state_nx     = ST_REPLY;
        case (cmd_r)
          CMD_LED: begin
            led_nx     = nib_r;
            tx_data_nx = ASC_K;
          end
          CMD_SET: begin
            led_nx[idx_r] = bit_r;
            tx_data_nx    = ASC_K;
          end
          CMD_QUERY: begin
            tx_data_nx = enc_asc_s;
          end
          default: begin
            tx_data_nx = ASC_E;
          end
        endcase
      end
      ST_REPLY: begin
        frame_err_nx = rx_done;
        if (tx_ready) begin
          tx_en_nx = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = cur_s;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      cmd_r       <= CMD_LED;
      nib_r       <= 4'h0;
      idx_r       <= 2'd0;
      bit_r       <= 1'b0;
      led_r       <= LED_RST;
      tx_en_r     <= 1'b0;
      tx_data_r   <= 8'h00;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cmd_r       <= cmd_nx;
      nib_r       <= nib_nx;
      idx_r       <= idx_nx;
      bit_r       <= bit_nx;
      led_r       <= led_nx;
      tx_en_r     <= tx_en_nx;
      tx_data_r   <= tx_data_nx;
      frame_err_r <= frame_err_nx;
    end
  end

  assign tx_en     = tx_en_r;
  assign tx_data   = tx_data_r;
  assign led       = led_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_bh_cmd_parser.sv
// Self-checking bench for bh_cmd_parser: frame-level reference model plus
// a per-cycle compare process; covers BH_CMD_TIMEOUT_EN when defined.
module tb_bh_cmd_parser;

  localparam logic [3:0] LED_INIT = 4'h9;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [3:0] led;
  logic       frame_err;

  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;
  int         err_exp = 0;
  logic [3:0] model_led = LED_INIT;
  logic [7:0] reply_q[$];
  logic [7:0] last_reply = 8'h00;
  logic       prev_tx_en = 1'b0;

  bh_cmd_parser #(.TIMEOUT_CYC(100), .LED_RST(LED_INIT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .tx_ready  (tx_ready),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .led       (led),
    .frame_err (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    else if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    else if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    else return -1;
  endfunction

  // Frame-level reference: the command text (without terminator) decides everything.
  task automatic model_frame(input string s, input logic [3:0] led_in,
                             output logic [3:0] led_out, output logic [7:0] reply,
                             output logic has_reply, output logic err);
    int n;
    n = s.len();
    led_out = led_in; reply = 8'h45; has_reply = 1'b1; err = 1'b0;
    if (n == 0) begin
      has_reply = 1'b0;
    end else if ((s[0] == 8'h4C || s[0] == 8'h6C) && n == 2 && hexval(s[1]) >= 0) begin
      led_out = 4'(hexval(s[1]));
      reply = 8'h4B;
    end else if ((s[0] == 8'h53 || s[0] == 8'h73) && n == 3 && s[1] >= 8'h30 && s[1] <= 8'h33 &&
                 (s[2] == 8'h30 || s[2] == 8'h31)) begin
      led_out[int'(s[1]) - 48] = s[2][0];
      reply = 8'h4B;
    end else if (s == "?") begin
      reply = (led_in < 4'd10) ? 8'h30 + {4'h0, led_in} : 8'h37 + {4'h0, led_in};
    end else begin
      err = 1'b1;
    end
  endtask

  // Compare process: led every cycle, reply bytes on tx_en, frame_err counting.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      check("led", {28'h0, led}, {28'h0, model_led});
      if (tx_en) begin
        if (prev_tx_en) check("tx_en_width", 32'd2, 32'd1);
        if (reply_q.size() == 0) begin
          check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, reply_q.pop_front()});
        end
        last_reply = tx_data;
      end
      if (frame_err) err_seen++;
    end
    prev_tx_en = tx_en;
  end

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    cycle();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 40 && reply_q.size() != 0; i++) cycle();
    cycle();
    check("reply_drained", reply_q.size(), 32'd0);
    check("frame_err_count", err_seen, err_exp);
  endtask

  task automatic send_frame(input string s, input logic [7:0] term, input int skip, input bit do_wait);
    logic [3:0] lo;
    logic [7:0] rp;
    logic       hr, er;
    for (int i = skip; i < s.len(); i++) send_byte(s[i]);
    send_byte(term);
    model_frame(s, model_led, lo, rp, hr, er);
    if (hr) reply_q.push_back(rp);
    if (er) err_exp++;
    cycle();
    model_led = lo;
    if (do_wait) wait_quiet();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    cycle();
    sys_rst = 1'b0;
    reply_q.delete();
    model_led = LED_INIT;
  endtask

  initial begin
    sys_rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) cycle();
    sys_rst = 1'b0;
    check("rst_led", {28'h0, led}, 32'h9);
    check("rst_tx_en", {31'h0, tx_en}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);

    send_frame("?", 8'h0D, 0, 1'b1);
    check("q_reset_reply", {24'h0, last_reply}, 32'h39);
    send_frame("LA", 8'h0D, 0, 1'b1);
    check("la_led", {28'h0, led}, 32'hA);
    check("la_reply", {24'h0, last_reply}, 32'h4B);
    send_frame("S01", 8'h0A, 0, 1'b1);
    send_frame("?", 8'h0A, 0, 1'b1);
    check("s01_led", {28'h0, led}, 32'hB);
    check("q_b_reply", {24'h0, last_reply}, 32'h42);
    send_frame("lc", 8'h0D, 0, 1'b1);
    send_frame("LG", 8'h0D, 0, 1'b1);
    check("lg_led", {28'h0, led}, 32'hC);
    check("lg_reply", {24'h0, last_reply}, 32'h45);
    check("lg_err", err_seen, 32'd1);
    send_frame("", 8'h0D, 0, 1'b1);
    send_frame("S2", 8'h0D, 0, 1'b1);
    send_frame("S41", 8'h0A, 0, 1'b1);
    send_frame("?X", 8'h0D, 0, 1'b1);
    send_frame("s30", 8'h0A, 0, 1'b1);
    send_frame("?", 8'h0D, 0, 1'b1);
    check("s30_reply", {24'h0, last_reply}, 32'h34);

    // Reply held off by tx_ready; a byte arriving meanwhile is dropped.
    tx_ready = 1'b0;
    send_frame("L5", 8'h0A, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        send_byte(8'h58);
        err_exp++;
      end else begin
        cycle();
      end
      check("hold_tx_en", {31'h0, tx_en}, 32'h0);
    end
    tx_ready = 1'b1;
    wait_quiet();
    check("hold_reply", {24'h0, last_reply}, 32'h4B);

    // Reset during a pending reply discards it.
    tx_ready = 1'b0;
    send_frame("L1", 8'h0D, 0, 1'b0);
    repeat (3) cycle();
    do_reset();
    tx_ready = 1'b1;
    repeat (10) cycle();
    check("rst_reply_led", {28'h0, led}, 32'h9);

    // Reset mid-frame, then a normal command.
    send_byte(8'h53);
    send_byte(8'h32);
    do_reset();
    check("rst_frame_led", {28'h0, led}, 32'h9);
    send_frame("L3", 8'h0A, 0, 1'b1);
    check("l3_led", {28'h0, led}, 32'h3);

`ifdef BH_CMD_TIMEOUT_EN
    send_byte(8'h4C);
    repeat (105) cycle();
    err_exp++;
    check("timeout_err", err_seen, err_exp);
    send_frame("L7", 8'h0A, 0, 1'b1);
    check("after_timeout_led", {28'h0, led}, 32'h7);
`else
    send_byte(8'h4C);
    repeat (120) cycle();
    check("no_timeout_err", err_seen, err_exp);
    send_frame("L7", 8'h0A, 1, 1'b1);
    check("late_l7_led", {28'h0, led}, 32'h7);
`endif

    check("final_err_count", err_seen, err_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
